usb_rx_unstuffer: RTL
=====================

# usb_rx_unstuffer

Receive-path stage directly downstream of the NRZI decoder. Takes the decoded serial bitstream, hunts for the SYNC pattern, strips stuffed zeros, flags bit-stuff violations, and assembles LSB-first bytes for the packet layer. One byte strobe per eight payload bits; all state clears when the receive window closes.

## Interface
- `ONES_LIMIT`, default 6: consecutive-ones count after which the next bit is a stuffed bit.
- `SYNC_PATTERN`, default 8'h80: byte value that ends the SYNC hunt. This is the LSB-first assembly of the bit sequence 0,0,0,0,0,0,0,1.
- `clk`, input, 1: system clock.
- `RST`, input, 1: reset, asynchronous, active-high.
- `rx_active`, input, 1: receive window open. This matches the decoder's enable.
- `bit_valid`, input, 1: single-cycle strobe, one per USB bit time.
- `decoded_bit`, input, 1: NRZI-decoded bit. Sampled only when `bit_valid`=1.
- `data_out`, output, 8: last completed byte. Held between strobes.
- `data_valid`, output, 1: single-cycle strobe that marks a new `data_out`.
- `sync_found`, output, 1: single-cycle pulse when SYNC is matched.
- `stuff_err`, output, 1: level. Set on a stuff violation; cleared on leaving the receive window.
- `partial_err`, output, 1: single-cycle pulse when the window closes mid-byte.

## Operation
- States: IDLE, HUNT, DATA, ERROR.
- IDLE:
  - Shift register, bit counter and ones counter are held at 0.
  - `rx_active`=1 → HUNT.
- HUNT:
  - Each valid bit shifts into the MSB of an 8-bit shift register (right shift).
  - When the register equals `SYNC_PATTERN` → DATA. This pulses `sync_found` and clears the bit counter.
- DATA:
  - Each valid, non-stuffed bit shifts into the byte register and increments the 3-bit bit counter.
  - On counter wrap 7→0, the shifted value loads `data_out` and `data_valid` pulses.
- Ones counter:
  - Runs in HUNT and DATA, so the trailing SYNC 1 counts toward stuffing.
  - It increments on a valid 1 and clears on a valid 0. It saturates at `ONES_LIMIT`.
- Stuffed bit: the valid bit following `ONES_LIMIT` consecutive ones.
  - If it is 0: drop it (no shift, no count) and clear the ones counter.
  - If it is 1: stuff violation (see Configuration).
- ERROR:
  - `stuff_err`=1. No `data_valid` and no shifting.
  - Held until `rx_active`=0.
- `rx_active`=0 in any state → IDLE next cycle. The partial byte is discarded.
  - If in DATA with bit counter ≠ 0, `partial_err` pulses.
  - `stuff_err` clears.
- Priority: `rx_active`=0 beats `bit_valid` in the same cycle; that bit is ignored.
- `bit_valid` while `rx_active`=0 is ignored.

## Timing
- Reset values:
  - state IDLE.
  - `data_out`=8'h00.
  - `data_valid`, `sync_found`, `stuff_err`, `partial_err` all 0.
  - Internal counters and registers 0.
- All outputs are registered.
- `data_valid` asserts the cycle after the `bit_valid` that delivers the 8th payload bit. Latency 1 clk.
- `sync_found` asserts the cycle after the SYNC-completing bit. The first data bit may arrive the following cycle.
- `stuff_err` rises the cycle after the violating bit.
- `partial_err` and the IDLE transition occur the cycle after `rx_active` falls.
- `RST` mid-packet clears everything immediately. No strobes are emitted.
- Back-to-back `bit_valid` on every clock must be sustained with no bubbles.

## Configuration
- `USB_RX_STUFF_ERR_EN` defined:
  - A 1 arriving in the stuffed-bit slot → ERROR with `stuff_err`=1.
- Undefined:
  - A 1 in the stuffed-bit slot is still dropped and the ones counter resets to 1.
  - No ERROR state is reachable.
  - `stuff_err` is tied 0.

## Structure
- Package `usb_rx_pkg` holds:
  - the state enum `rx_state_t`;
  - the default `USB_SYNC_BYTE` = 8'h80;
  - the default `USB_STUFF_LIMIT` = 6.
- Sub-module `stuff_detector` holds the ones counter. It produces `drop_bit` and `stuff_violation` from `bit_valid`, `decoded_bit` and a clear input. The top level holds the FSM, the shift register and the byte counter.

## Test plan
- Reset with `rx_active`=1, then bits 0,0,0,0,0,0,0,1 → `sync_found` pulse; then byte 8'hA5 LSB-first → `data_out`=8'hA5, one `data_valid`.
- After SYNC send 8'hFF:
  - Insert a 0 after the 5th payload 1. The SYNC 1 plus 5 payload ones makes six, so this 0 is the stuffed bit.
  - Required: `data_out`=8'hFF, exactly one `data_valid`, the stuffed 0 absent from the data.
- Same as previous, but a 1 in the stuff slot, built with `USB_RX_STUFF_ERR_EN`:
  - `stuff_err`=1 the next cycle.
  - No `data_valid` afterwards until `rx_active` falls, after which `stuff_err`=0.
- Same stream with the macro undefined → `stuff_err` stays 0 and byte assembly continues.
- After SYNC send 3 payload bits, then drop `rx_active` → one `partial_err` pulse, no `data_valid`, state IDLE.
- Assert `RST` mid-byte with `bit_valid` toggling:
  - All outputs are 0 immediately.
  - A fresh SYNC plus 8'h3C after release → `data_out`=8'h3C.

Source files
------------

// File: rtl/usb_rx_unstuffer_pkg.sv
// usb_rx_pkg: shared state encoding and protocol defaults for the USB receive unstuffer
package usb_rx_pkg;
  typedef enum logic [1:0] {IDLE, HUNT, DATA, ERROR} rx_state_t;
  localparam logic [7:0] USB_SYNC_BYTE   = 8'h80;
  localparam int         USB_STUFF_LIMIT = 6;
endpackage

// File: rtl/usb_rx_unstuffer_stuff_detector.sv
// stuff_detector: counts consecutive ones and flags the bit slot that must carry a stuffed zero
module stuff_detector
  import usb_rx_pkg::*;
#(
  parameter int ONES_LIMIT = USB_STUFF_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bit_valid,
  input  logic decoded_bit,
  output logic drop_bit,
  output logic stuff_violation
);
  localparam int W = $clog2(ONES_LIMIT + 1);
  logic [W-1:0] r_ones;
  logic         w_slot;
  assign w_slot          = r_ones == W'(ONES_LIMIT);
  assign drop_bit        = bit_valid & w_slot;
  assign stuff_violation = drop_bit & decoded_bit;
  // Ones run length; a 1 in the stuff slot restarts the run at one, which also bounds the count
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ones <= '0;
    else if (clear) r_ones <= '0;
    else if (bit_valid) r_ones <= !decoded_bit ? '0 : w_slot ? W'(1) : r_ones + 1'b1;
endmodule

// File: rtl/usb_rx_unstuffer.sv
// usb_rx_unstuffer: SYNC hunt, zero unstuffing and LSB-first byte assembly (USB_RX_STUFF_ERR_EN enables the ERROR state)
module usb_rx_unstuffer
  import usb_rx_pkg::*;
#(
  parameter int         ONES_LIMIT   = USB_STUFF_LIMIT,
  parameter logic [7:0] SYNC_PATTERN = USB_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       rx_active,
  input  logic       bit_valid,
  input  logic       decoded_bit,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       sync_found,
  output logic       stuff_err,
  output logic       partial_err
);
  rx_state_t   r_state, w_next;
  logic [7:0]  r_shift, w_shift, r_data_out;
  logic [2:0]  r_cnt;
  logic        r_data_valid, r_sync_found, r_partial_err;
  logic        w_live, w_bv, w_drop, w_viol, w_take, w_sync, w_err;
  assign w_live  = rx_active & (r_state == HUNT | r_state == DATA);
  assign w_bv    = w_live & bit_valid;
  assign w_shift = {decoded_bit, r_shift[7:1]};
  assign w_take  = w_bv & ~w_drop;
  assign w_sync  = w_take & r_state == HUNT & w_shift == SYNC_PATTERN;
  stuff_detector #(.ONES_LIMIT(ONES_LIMIT)) u_det (
    .clk            (clk),
    .rst            (RST),
    .clear          (~w_live),
    .bit_valid      (w_bv),
    .decoded_bit    (decoded_bit),
    .drop_bit       (w_drop),
    .stuff_violation(w_viol)
  );
`ifdef USB_RX_STUFF_ERR_EN
  logic r_stuff_err;
  assign w_err     = w_viol;
  assign stuff_err = r_stuff_err;
  // Violation flag is sticky for the rest of the receive window
  always_ff @(posedge clk or posedge RST)
    if (RST) r_stuff_err <= 1'b0;
    else r_stuff_err <= rx_active & (r_stuff_err | w_err);
`else
  logic w_unused;
  assign w_unused  = w_viol;
  assign w_err     = 1'b0;
  assign stuff_err = 1'b0;
`endif
  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign sync_found  = r_sync_found;
  assign partial_err = r_partial_err;
  // State register
  always_ff @(posedge clk or posedge RST)
    if (RST) r_state <= IDLE;
    else r_state <= w_next;
  // Next state: closing the window wins over any bit arriving in the same cycle
  always_comb begin
    w_next = r_state;
    if (!rx_active) w_next = IDLE;
    else if (r_state == IDLE) w_next = HUNT;
    else if (w_err) w_next = ERROR;
    else if (w_sync) w_next = DATA;
  end
  // Shift register, bit counter and registered strobes
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      r_shift       <= 8'h00;
      r_cnt         <= 3'd0;
      r_data_out    <= 8'h00;
      r_data_valid  <= 1'b0;
      r_sync_found  <= 1'b0;
      r_partial_err <= 1'b0;
    end else begin
      r_data_valid  <= 1'b0;
      r_sync_found  <= 1'b0;
      r_partial_err <= !rx_active && r_state == DATA && r_cnt != 3'd0;
      if (!w_live) begin
        r_shift <= 8'h00;
        r_cnt   <= 3'd0;
      end else if (w_sync) begin
        r_shift      <= 8'h00;
        r_cnt        <= 3'd0;
        r_sync_found <= 1'b1;
      end else if (w_take) begin
        r_shift <= w_shift;
        if (r_state == DATA) begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_data_out   <= w_shift;
            r_data_valid <= 1'b1;
          end
        end
      end
    end
endmodule
